tx_out_mem: RTL and testbench
=============================

// Module: tx_out_mem
// PURPOSE
//  TX-side output sample buffer for the WiFi PHY. It sits between the TX baseband chain and the DAC/AFE interface.
//  Accepts DATA-bit samples plus an end-of-frame mark from the TX chain. Stores them in a MEM-deep circular RAM.
//  Streams them out with a valid/ready handshake once a start level is reached or a complete frame is buffered.
// PARAMETERS
//  AD        14    address width of read/write pointers
//  DATA      12    sample width
//  MEM       8000  RAM depth in words (must be <= 2**AD)
//  START_LVL 64    occupancy that starts streaming without a complete frame (1..MEM)
// PORTS
//  clk        in   1       single clock, all logic on posedge
//  reset      in   1       synchronous, active-high
//  we         in   1       sample write strobe from TX chain
//  data_in    in   DATA    sample to store
//  last_in    in   1       qualifies we: this sample ends a frame
//  ready_in   in   1       downstream accepts data_out this cycle
//  data_out   out  DATA    output sample (registered)
//  valid_out  out  1       data_out valid
//  last_out   out  1       data_out is last sample of frame
//  full       out  1       count == MEM
//  empty      out  1       count == 0
//  count      out  AD+1    words accepted and not yet handshaken out
//  overflow   out  1       sticky: write attempted while full
//  underrun   out  1       sticky: ran dry while streaming mid-frame
// BEHAVIOUR
//  Reset (sync, high): pointers, count, frames_pending=0; state=IDLE; valid_out, last_out, overflow, underrun=0; data_out=0; empty=1, full=0. RAM contents not cleared.
//  Reset mid-stream aborts the frame immediately; buffered data is discarded.
//  Write: we && !full -> ram[wr_ptr] <= {last_in,data_in}; wr_ptr wraps MEM-1 -> 0; count+1.
//  Write: we && full -> word dropped, no state change, overflow <= 1 (held until reset).
//  Accepted write with last_in increments frames_pending.
//  Handshake = valid_out && ready_in. It decrements count. If last_out is set it also decrements frames_pending.
//  Simultaneous accepted write and handshake: count unchanged. A word in the output register still counts toward full.
//  Output register: single stage. Load when (!valid_out || ready_in) && rd_ptr != wr_ptr-in-use && state==STREAM.
//  A load reads ram[rd_ptr]; rd_ptr wraps MEM-1 -> 0; next cycle valid_out=1 with data/last.
//  While valid_out && !ready_in, data_out and last_out hold stable.
//  Back-to-back handshakes sustain 1 word/cycle while words remain.
//  FSM:
//   IDLE: no loads.
//    -> STREAM when count >= START_LVL or frames_pending != 0 (registered values).
//   STREAM: loads per rule above.
//    If no word is available to load, a handshake empties the output reg, and the last handshaken word was not last: underrun <= 1, valid_out=0, remain STREAM.
//    Handshake with last_out=1 -> IDLE; no further load that cycle.
//  Latency: accepted write at cycle N that satisfies the start condition -> count/frames_pending at N+1 -> STREAM at N+2 -> valid_out at N+3.
//  full/empty are combinational from registered count.
// TESTING
//  1. Reset then idle -> empty=1, full=0, count=0, valid_out=0, overflow=underrun=0.
//  2. START_LVL=64; write 10 words, last on word 10, ready_in=1.
//     -> valid_out 3 cycles after word 10; 10 consecutive outputs, last_out on 10th; returns to IDLE; count=0.
//  3. Write 63 words without last -> valid_out stays 0; 64th word -> streaming starts.
//     Hold ready_in=0 -> data_out stable, count=64.
//  4. MEM=16: write 20 words, ready_in=0 -> full=1 at 16, words 17-20 dropped, overflow=1.
//     Drain -> exactly words 1-16 out in order.
//  5. Stream 70-word frame past START_LVL, stop writes at 66 -> underrun=1 after word 66.
//     Resume writes 67-70 -> output resumes in order, last_out on 70.
//  6. Wrap test MEM=16: three 12-word frames with continuous ready_in -> data order intact across pointer wrap.
//     Reset asserted mid-frame -> next cycle valid_out=0, count=0.

Source files
------------

// File: rtl/tx_out_mem_if.sv
// tx_out_mem_if
//   Bundles the TX-chain write side, the DAC-side valid/ready stream and the
//   buffer status flags of tx_out_mem.
//   master : TX chain / DAC side (drives we, data_in, last_in, ready_in)
//   slave  : the buffer itself (drives stream outputs and status)
interface tx_out_mem_if #(
    parameter int AD   = 14,
    parameter int DATA = 12
);
    logic            we;
    logic [DATA-1:0] data_in;
    logic            last_in;
    logic            ready_in;
    logic [DATA-1:0] data_out;
    logic            valid_out;
    logic            last_out;
    logic            full;
    logic            empty;
    logic [AD:0]     count;
    logic            overflow;
    logic            underrun;

    modport master (
        output we, data_in, last_in, ready_in,
        input  data_out, valid_out, last_out, full, empty, count, overflow, underrun
    );

    modport slave (
        input  we, data_in, last_in, ready_in,
        output data_out, valid_out, last_out, full, empty, count, overflow, underrun
    );
endinterface

// File: rtl/tx_out_mem.sv
// tx_out_mem
//   TX-side output sample buffer between the TX baseband chain and the DAC/AFE.
//   Samples plus an end-of-frame mark are stored in a MEM-deep circular RAM
//   and streamed out through a single registered output stage once START_LVL
//   words are buffered or a complete frame is waiting.
// Ports
//   clk    : single clock, all logic on posedge
//   reset  : synchronous, active-high
//   bus    : tx_out_mem_if.slave (write side, output stream, status flags)
//
// state  | meaning
// IDLE   | buffering, no loads into the output register
// STREAM | loading the output register whenever a word is available
module tx_out_mem #(
    parameter int AD        = 14,
    parameter int DATA      = 12,
    parameter int MEM       = 8000,
    parameter int START_LVL = 64
) (
    input logic         clk,
    input logic         reset,
    tx_out_mem_if.slave bus
);
    localparam int          RAM_AW  = (MEM > 1) ? $clog2(MEM) : 1;
    localparam logic [AD:0] MEM_C   = (AD+1)'(MEM);
    localparam logic [AD:0] START_C = (AD+1)'(START_LVL);
    localparam logic [AD-1:0] PTR_LAST = AD'(MEM - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t          state_q, state_d;
    logic [DATA:0]   ram [MEM];
    logic [AD-1:0]   wr_ptr, rd_ptr;
    logic [AD:0]     count_q, pend_q;
    logic [DATA-1:0] data_q;
    logic            valid_q, valid_d, last_q;
    logic            overflow_q, underrun_q;
    logic            full, hs, wr_acc, avail, load, underrun_set;

    assign full   = (count_q == MEM_C);
    assign hs     = valid_q && bus.ready_in;
    assign wr_acc = bus.we && !full;
    // count includes the word sitting in the output register, so the RAM
    // holds an unloaded word only when count exceeds valid_out.
    assign avail  = (count_q != {{AD{1'b0}}, valid_q});

    always_comb begin
        state_d      = state_q;
        load         = 1'b0;
        underrun_set = 1'b0;
        valid_d      = valid_q;
        case (state_q)
            IDLE: begin
                if (count_q >= START_C || pend_q != '0) state_d = STREAM;
            end
            STREAM: begin
                if (hs && last_q) begin
                    state_d = IDLE;
                end else if ((!valid_q || bus.ready_in) && avail) begin
                    load = 1'b1;
                end else if (hs) begin
                    // output register drains mid-frame with nothing behind it
                    underrun_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load)    valid_d = 1'b1;
        else if (hs) valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wr_acc) ram[wr_ptr[RAM_AW-1:0]] <= {bus.last_in, bus.data_in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            pend_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            if (load) begin
                data_q <= ram[rd_ptr[RAM_AW-1:0]][DATA-1:0];
                last_q <= ram[rd_ptr[RAM_AW-1:0]][DATA];
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end else if (hs) begin
                last_q <= 1'b0;
            end
            if (wr_acc) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            count_q <= count_q + {{AD{1'b0}}, wr_acc} - {{AD{1'b0}}, hs};
            pend_q  <= pend_q + {{AD{1'b0}}, wr_acc && bus.last_in}
                              - {{AD{1'b0}}, hs && last_q};
            if (bus.we && full) overflow_q <= 1'b1;
            if (underrun_set)   underrun_q <= 1'b1;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.last_out  = last_q;
    assign bus.full      = full;
    assign bus.empty     = (count_q == '0);
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underrun  = underrun_q;
endmodule

// File: tb/tb_tx_out_mem.sv
// tb_tx_out_mem
//   Directed bench for tx_out_mem: one large instance (MEM=8000, START_LVL=64)
//   and one small instance (MEM=16, START_LVL=16) for full/overflow and wrap.
module tb_tx_out_mem;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tx_out_mem_if #(.AD(14), .DATA(12)) ifa();
    tx_out_mem_if #(.AD(4),  .DATA(12)) ifb();

    tx_out_mem #(.AD(14), .DATA(12), .MEM(8000), .START_LVL(64))
        dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    tx_out_mem #(.AD(4), .DATA(12), .MEM(16), .START_LVL(16))
        dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [12:0] q_word[$];
    int          q_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // drive one cycle of write-side stimulus on instance b (0=a, 1=b),
    // record any handshake visible this cycle, then advance one clock
    task automatic step(input bit b, input bit we, input int d, input bit l);
        if (!b) begin
            ifa.we = we; ifa.data_in = 12'(d); ifa.last_in = l;
            if (ifa.valid_out && ifa.ready_in) begin
                q_word.push_back({ifa.last_out, ifa.data_out});
                q_cyc.push_back(cyc);
            end
        end else begin
            ifb.we = we; ifb.data_in = 12'(d); ifb.last_in = l;
            if (ifb.valid_out && ifb.ready_in) begin
                q_word.push_back({ifb.last_out, ifb.data_out});
                q_cyc.push_back(cyc);
            end
        end
        tick();
    endtask

    task automatic do_reset();
        ifa.we = 0; ifa.data_in = '0; ifa.last_in = 0; ifa.ready_in = 0;
        ifb.we = 0; ifb.data_in = '0; ifb.last_in = 0; ifb.ready_in = 0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        q_word.delete();
        q_cyc.delete();
    endtask

    function automatic logic [12:0] qw(input int i);
        if (i < q_word.size()) return q_word[i];
        return 13'h1fff;
    endfunction

    initial begin
        int t0;
        int first;
        logic [12:0] e;

        // 1: reset state
        do_reset();
        chk("rst_empty", ifa.empty, 1);
        chk("rst_full", ifa.full, 0);
        chk("rst_count", ifa.count, 0);
        chk("rst_valid", ifa.valid_out, 0);
        chk("rst_ovf", ifa.overflow, 0);
        chk("rst_udr", ifa.underrun, 0);
        chk("rst_b_empty", ifb.empty, 1);

        // 2: short frame, released by the end-of-frame mark
        ifa.ready_in = 1;
        t0 = cyc;
        for (int k = 0; k < 10; k++) step(0, 1, 256 + k, k == 9);
        for (int k = 0; k < 20; k++) step(0, 0, 0, 0);
        first = (q_cyc.size() > 0) ? q_cyc[0] - t0 : -1;
        chk("t2_first_valid", first, 12);
        chk("t2_nwords", q_word.size(), 10);
        if (q_cyc.size() == 10) chk("t2_back2back", q_cyc[9] - q_cyc[0], 9);
        for (int i = 0; i < 10; i++) begin
            e = 13'(256 + i);
            e[12] = (i == 9);
            chk("t2_word", qw(i), e);
        end
        chk("t2_count", ifa.count, 0);
        chk("t2_valid_idle", ifa.valid_out, 0);

        // 3: start level
        do_reset();
        for (int k = 0; k < 63; k++) step(0, 1, 512 + k, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0);
        chk("t3_no_start", ifa.valid_out, 0);
        chk("t3_count63", ifa.count, 63);
        step(0, 1, 512 + 63, 0);
        step(0, 0, 0, 0);
        chk("t3_lat_pre", ifa.valid_out, 0);
        step(0, 0, 0, 0);
        chk("t3_valid", ifa.valid_out, 1);
        chk("t3_data", ifa.data_out, 512);
        chk("t3_count64", ifa.count, 64);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
        chk("t3_hold_data", ifa.data_out, 512);
        chk("t3_hold_valid", ifa.valid_out, 1);
        chk("t3_hold_count", ifa.count, 64);

        // 5: underrun mid-frame, then resume
        do_reset();
        ifa.ready_in = 1;
        for (int k = 0; k < 66; k++) step(0, 1, 1280 + k, 0);
        chk("t5_udr_early", ifa.underrun, 0);
        for (int k = 0; k < 80; k++) step(0, 0, 0, 0);
        chk("t5_udr", ifa.underrun, 1);
        chk("t5_valid_dry", ifa.valid_out, 0);
        chk("t5_n66", q_word.size(), 66);
        for (int k = 66; k < 70; k++) step(0, 1, 1280 + k, k == 69);
        for (int k = 0; k < 20; k++) step(0, 0, 0, 0);
        chk("t5_n70", q_word.size(), 70);
        for (int i = 0; i < 70; i++) begin
            e = 13'(1280 + i);
            e[12] = (i == 69);
            chk("t5_word", qw(i), e);
        end
        chk("t5_count", ifa.count, 0);

        // 4: full / overflow on the 16-deep instance
        do_reset();
        for (int k = 0; k < 20; k++) begin
            if (k == 16) begin
                chk("t4_full16", ifb.full, 1);
                chk("t4_count16", ifb.count, 16);
                chk("t4_ovf_pre", ifb.overflow, 0);
            end
            step(1, 1, 768 + k, 0);
        end
        chk("t4_ovf", ifb.overflow, 1);
        chk("t4_count_hold", ifb.count, 16);
        ifb.ready_in = 1;
        for (int k = 0; k < 30; k++) step(1, 0, 0, 0);
        chk("t4_n16", q_word.size(), 16);
        for (int i = 0; i < 16; i++) chk("t4_word", qw(i), 13'(768 + i));
        chk("t4_empty", ifb.empty, 1);
        chk("t4_ovf_sticky", ifb.overflow, 1);

        // 6: wrap with three 12-word frames, then reset mid-frame
        do_reset();
        ifb.ready_in = 1;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 12; k++) step(1, 1, 1024 + f * 12 + k, k == 11);
            for (int k = 0; k < 20; k++) step(1, 0, 0, 0);
        end
        chk("t6_n36", q_word.size(), 36);
        for (int i = 0; i < 36; i++) begin
            e = 13'(1024 + i);
            e[12] = ((i % 12) == 11);
            chk("t6_word", qw(i), e);
        end
        for (int k = 0; k < 12; k++) step(1, 1, 1536 + k, k == 11);
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0);
        chk("t6_midframe", ifb.valid_out, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_valid", ifb.valid_out, 0);
        chk("t6_rst_count", ifb.count, 0);
        chk("t6_rst_empty", ifb.empty, 1);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("t6_discarded", ifb.valid_out, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
